// File: rtl/stopwatch_seg_scan.sv
// Stopwatch display scanner: snapshots minute/second/10ms once per scan frame,
// converts them to BCD with a serial double-dabble engine and drives a 6-digit MM.SS.ss display.
module stopwatch_seg_scan #(
  parameter int SCAN_DIV       = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] minute,
  input  logic [7:0] second,
  input  logic [7:0] millsecond_10,
  output logic [7:0] seg,
  output logic [5:0] dig_sel,
  output logic       ovf,
  output logic       conv_busy
);

  localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [7:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0]     DIG_OFF   = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} conv_state_t;

  conv_state_t   state, state_nxt;
  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;
  logic          first_cyc;
  logic          scan_last, frame_start, conv_done;

  logic [7:0]    snap_sec, snap_ms;
  logic [19:0]   sr, sr_adj, sr_shift;
  logic [2:0]    bit_cnt;
  logic [1:0]    field;
  logic [3:0]    stage_dig [6];
  logic          stage_ovf;
  logic [3:0]    disp_dig [6];
  logic          disp_ovf;

  logic [3:0]    cur_dig;
  logic          cur_dp;
  logic [7:0]    seg_raw, seg_nxt;
  logic [5:0]    dig_raw, dig_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Frame start is the last cycle of digit 5, plus the first cycle out of reset.
  assign scan_last   = (scan_cnt == SCAN_LAST);
  assign frame_start = first_cyc | (scan_last & (idx == 3'd5));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      idx       <= '0;
      first_cyc <= 1'b1;
    end else begin
      first_cyc <= 1'b0;
      if (scan_last) begin
        scan_cnt <= '0;
        idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  assign conv_done = (state == S_CONV) && (bit_cnt == 3'd7) && (field == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frame_start) state_nxt = S_CONV;
      S_CONV:   if (conv_done)   state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign conv_busy = (state != S_IDLE);
  assign ovf       = disp_ovf;

  // Double-dabble step: correct each BCD nibble, then shift {bcd12, bin8} left.
  always_comb begin
    sr_adj = sr;
    if (sr[19:16] >= 4'd5) sr_adj[19:16] = sr[19:16] + 4'd3;
    if (sr[15:12] >= 4'd5) sr_adj[15:12] = sr[15:12] + 4'd3;
    if (sr[11:8]  >= 4'd5) sr_adj[11:8]  = sr[11:8]  + 4'd3;
  end
  assign sr_shift = {sr_adj[18:0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_sec  <= '0;
      snap_ms   <= '0;
      sr        <= '0;
      bit_cnt   <= '0;
      field     <= '0;
      stage_ovf <= 1'b0;
      disp_ovf  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        stage_dig[i] <= '0;
        disp_dig[i]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            snap_sec <= second;
            snap_ms  <= millsecond_10;
            sr       <= {12'd0, minute};
            bit_cnt  <= '0;
            field    <= '0;
          end
        end
        S_CONV: begin
          sr      <= sr_shift;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (field)
              2'd0: begin
                stage_dig[0] <= sr_shift[15:12];
                stage_dig[1] <= sr_shift[11:8];
                stage_ovf    <= (sr_shift[19:16] != 4'd0);
                sr           <= {12'd0, snap_sec};
              end
              2'd1: begin
                stage_dig[2] <= sr_shift[15:12];
                stage_dig[3] <= sr_shift[11:8];
                stage_ovf    <= stage_ovf | (sr_shift[19:16] != 4'd0);
                sr           <= {12'd0, snap_ms};
              end
              default: begin
                stage_dig[4] <= sr_shift[15:12];
                stage_dig[5] <= sr_shift[11:8];
                stage_ovf    <= stage_ovf | (sr_shift[19:16] != 4'd0);
              end
            endcase
            field <= field + 2'd1;
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < 6; i++) disp_dig[i] <= stage_dig[i];
          disp_ovf <= stage_ovf;
        end
        default: ;
      endcase
    end
  end

  // Decimal points sit after the minute and second digits.
  always_comb begin
    cur_dig = 4'd0;
    cur_dp  = 1'b0;
    case (idx)
      3'd0:    cur_dig = disp_dig[0];
      3'd1:    begin cur_dig = disp_dig[1]; cur_dp = 1'b1; end
      3'd2:    cur_dig = disp_dig[2];
      3'd3:    begin cur_dig = disp_dig[3]; cur_dp = 1'b1; end
      3'd4:    cur_dig = disp_dig[4];
      3'd5:    cur_dig = disp_dig[5];
      default: cur_dig = 4'd0;
    endcase
    seg_raw = {cur_dp, seg7(cur_dig)};
    dig_raw = 6'b000001 << idx;
    seg_nxt = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_nxt = DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg     <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg     <= seg_nxt;
      dig_sel <= dig_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_seg_scan.sv
// Bench for stopwatch_seg_scan: a cycle-level reference model derived from frame/commit timing
// checks every output each cycle, plus a vector table and hand sequences for commit timing and reset.
module tb_stopwatch_seg_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] minute, second, ms10;
  logic [7:0] seg;
  logic [5:0] dig_sel;
  logic       ovf, conv_busy;

  int tests = 0;
  int fails = 0;

  stopwatch_seg_scan #(.SCAN_DIV(8), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .minute(minute), .second(second), .millsecond_10(ms10),
    .seg(seg), .dig_sel(dig_sel), .ovf(ovf), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { int f; int m; int s; int ms; } snap_t;
  snap_t snaps[$];
  int    t = 0;  // rising edges since reset release

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [7:0] seg_of(input int d, input bit dp);
    logic [7:0] raw;
    raw = {dp, seg_tab[d]};
    return ~raw;
  endfunction

  function automatic int exp_digit(input snap_t sn, input int k);
    int v;
    case (k / 2)
      0:       v = sn.m;
      1:       v = sn.s;
      default: v = sn.ms;
    endcase
    v = v % 100;
    return (k % 2 == 0) ? v / 10 : v % 10;
  endfunction

  function automatic logic snap_ovf(input snap_t sn);
    return (sn.m > 99) || (sn.s > 99) || (sn.ms > 99);
  endfunction

  // Snapshot taken at frame start f becomes the display content from cycle f+26 on.
  function automatic snap_t disp_at(input int c);
    snap_t z;
    z = '{-1, 0, 0, 0};
    for (int i = snaps.size() - 1; i >= 0; i--)
      if (snaps[i].f + 26 <= c) return snaps[i];
    return z;
  endfunction

  function automatic logic busy_at(input int c);
    int r;
    if (c >= 1 && c <= 25) return 1'b1;
    if (c < 48) return 1'b0;
    r = (c - 47) % 48;
    return (r >= 1 && r <= 25);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      snaps.delete();
    end else begin
      if (t == 0 || t % 48 == 47)
        snaps.push_back('{t, int'(minute), int'(second), int'(ms10)});
      t++;
    end
  end

  always @(negedge clk) begin : mon
    int    k;
    snap_t d_prev, d_now;
    if (rst || t == 0) begin
      check("mon_rst_seg", 32'(seg), 32'hFF);
      check("mon_rst_dig", 32'(dig_sel), 32'h3F);
      check("mon_rst_ovf", 32'(ovf), 32'h0);
      check("mon_rst_busy", 32'(conv_busy), 32'h0);
    end else begin
      k      = ((t - 1) / 8) % 6;
      d_prev = disp_at(t - 1);
      d_now  = disp_at(t);
      check("mon_dig_sel", 32'(dig_sel), 32'(6'h3F & ~(6'b1 << k)));
      check("mon_seg", 32'(seg), 32'(seg_of(exp_digit(d_prev, k), (k == 1 || k == 3))));
      check("mon_ovf", 32'(ovf), 32'(snap_ovf(d_now)));
      check("mon_conv_busy", 32'(conv_busy), 32'(busy_at(t)));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_busy(input logic lvl, input string name);
    int n = 0;
    while (conv_busy !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (conv_busy !== lvl) check({name, "_busy_timeout"}, 32'(conv_busy), 32'(lvl));
  endtask

  // Called at the cycle conv_busy has just dropped: the committed digits occupy
  // the next six digit slots (idx 3,4,5,0,1,2) before the following commit.
  task automatic check_frame(input logic [23:0] dig, input logic ovf_exp, input string name);
    int k;
    int d;
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      k = (3 + j) % 6;
      d = int'(dig[23 - 4*k -: 4]);
      check({name, "_dig"}, 32'(dig_sel), 32'(6'h3F & ~(6'b1 << k)));
      check({name, "_seg"}, 32'(seg), 32'(seg_of(d, (k == 1 || k == 3))));
      check({name, "_ovf"}, 32'(ovf), 32'(ovf_exp));
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic check_commit(input logic [23:0] dig, input logic ovf_exp, input string name);
    wait_busy(1'b0, name);
    wait_busy(1'b1, name);
    wait_busy(1'b0, name);
    check_frame(dig, ovf_exp, name);
  endtask

  task automatic async_reset(input string name);
    #2 rst = 1'b1;
    #1;
    check({name, "_seg"}, 32'(seg), 32'hFF);
    check({name, "_dig"}, 32'(dig_sel), 32'h3F);
    check({name, "_ovf"}, 32'(ovf), 32'h0);
    check({name, "_busy"}, 32'(conv_busy), 32'h0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct { logic [7:0] m; logic [7:0] s; logic [7:0] ms; logic [23:0] dig; logic ov; } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'd12,  8'd34,  8'd56,  24'h123456, 1'b0};
    vecs[1] = '{8'd123, 8'd7,   8'd0,   24'h230700, 1'b1};
    vecs[2] = '{8'd7,   8'd7,   8'd0,   24'h070700, 1'b0};
    vecs[3] = '{8'd99,  8'd59,  8'd99,  24'h995999, 1'b0};
    vecs[4] = '{8'd0,   8'd0,   8'd0,   24'h000000, 1'b0};
    vecs[5] = '{8'd255, 8'd100, 8'd200, 24'h550000, 1'b1};
    vecs[6] = '{8'd45,  8'd9,   8'd3,   24'h450903, 1'b0};
    vecs[7] = '{8'd10,  8'd150, 8'd1,   24'h105001, 1'b1};

    minute = 8'd0; second = 8'd0; ms10 = 8'd0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rel_seg", 32'(seg), 32'hFF);
    check("rel_dig", 32'(dig_sel), 32'h3F);
    check("rel_ovf", 32'(ovf), 32'h0);
    check("rel_busy", 32'(conv_busy), 32'h0);
    wait_busy(1'b1, "first_conv");
    wait_busy(1'b0, "first_conv");
    check_frame(24'h000000, 1'b0, "first_conv");

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      minute = vecs[i].m; second = vecs[i].s; ms10 = vecs[i].ms;
      check_commit(vecs[i].dig, vecs[i].ov, $sformatf("vec%0d", i));
    end

    // Input change during CONV must not reach the display until the next snapshot.
    @(negedge clk);
    minute = 8'd10; second = 8'd29; ms10 = 8'd20;
    check_commit(24'h102920, 1'b0, "snap29");
    wait_busy(1'b1, "snap_chg");
    repeat (5) @(negedge clk);
    second = 8'd30;
    wait_busy(1'b0, "snap_chg");
    check_frame(24'h102920, 1'b0, "snap_hold29");
    wait_busy(1'b1, "snap30");
    wait_busy(1'b0, "snap30");
    check_frame(24'h103020, 1'b0, "snap30");

    // Reset in the middle of a conversion, display returns to zeros.
    @(negedge clk);
    minute = 8'd0; second = 8'd0; ms10 = 8'd0;
    wait_busy(1'b1, "mid_rst");
    repeat (10) @(negedge clk);
    async_reset("mid_rst");
    wait_busy(1'b1, "post_rst");
    wait_busy(1'b0, "post_rst");
    check_frame(24'h000000, 1'b0, "post_rst");

    // Random inputs, checked every cycle by the reference model.
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (c == 600) async_reset("rand_rst");
      if ($urandom_range(0, 11) == 0)
        minute = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 99));
      if ($urandom_range(0, 11) == 0)
        second = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 99));
      if ($urandom_range(0, 7) == 0)
        ms10 = 8'(($urandom_range(0, 3) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 99));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
